// File: rtl/sd_tx_pkg.sv
// sd_tx_pkg: states and constants for the SD DAT transmit path; SD_TX_CRC_STATUS_EN adds the status/busy states.
package sd_tx_pkg;
`ifdef SD_TX_CRC_STATUS_EN
  typedef enum logic [2:0] {IDLE, PRE, STARTB, DATA, CRC, ENDB, STAT, BUSYW} tx_state_t;
`else
  typedef enum logic [2:0] {IDLE, PRE, STARTB, DATA, CRC, ENDB} tx_state_t;
`endif
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam int CRC_LEN = 16;
  localparam logic [2:0] STAT_OK = 3'b010;
  localparam int STAT_TIMEOUT = 8;
endpackage

// File: rtl/sd_crc16.sv
// sd_crc16: serial CRC16 (x^16+x^12+x^5+1) for one DAT line, one bit per enabled cycle.
module sd_crc16
  import sd_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        d,
  output logic [15:0] crc
);
  logic fb;
  assign fb = d ^ crc[15];
  always_ff @(posedge clk) begin
    if (rst || clr) crc <= '0;
    else if (en) crc <= {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0);
  end
endmodule

// File: rtl/sd_data_tx.sv
// sd_data_tx: SD 4-bit DAT block serializer with per-line CRC16; SD_TX_CRC_STATUS_EN adds CRC-status and busy wait.
module sd_data_tx
  import sd_tx_pkg::*;
#(
  parameter int MAX_BLK_BYTES = 2048
)
(
  input  logic        sd_clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] blk_bytes,
  input  logic [31:0] fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_rd,
  input  logic [3:0]  dat_i,
  output logic [3:0]  dat_o,
  output logic        dat_oe,
  output logic        busy,
  output logic        done,
  output logic        underrun,
  output logic        crc_ok
);
  localparam int NW = $clog2(2 * MAX_BLK_BYTES);
  tx_state_t st;
  logic [31:0] sreg, word, ord;
  logic [NW-1:0] nib, nib_last;
  logic [3:0] cnt, nxt, crc_msb;
  logic load, last_nib, shifting, crc_en, crc_clr;
  logic [15:0] crc_q [4];
  logic unused_dat;
  assign word = fifo_empty ? 32'h0 : fifo_data;
  assign ord = {word[7:0], word[15:8], word[23:16], word[31:24]};
  assign last_nib = st == DATA && nib == nib_last;
  assign load = st == STARTB || (st == DATA && nib[2:0] == 3'd7 && !last_nib);
  assign nxt = load ? ord[31:28] : sreg[31:28];
  assign shifting = last_nib || st == CRC;
  assign crc_en = st == STARTB || st == DATA || st == CRC;
  assign crc_clr = st == IDLE && start;
  assign fifo_rd = load && !fifo_empty && !rst;
  for (genvar k = 0; k < 4; k++) begin : g_crc
    sd_crc16 u_crc (
      .clk(sd_clk),
      .rst(rst),
      .clr(crc_clr),
      .en(crc_en),
      .d(shifting ? crc_q[k][CRC_LEN-1] : nxt[k]),
      .crc(crc_q[k])
    );
    assign crc_msb[k] = crc_q[k][CRC_LEN-1];
  end
`ifdef SD_TX_CRC_STATUS_EN
  logic got_sb;
  logic [2:0] stat_sh;
  assign unused_dat = ^dat_i[3:1];
`else
  assign unused_dat = ^dat_i;
  assign crc_ok = 1'b1;
`endif
  always_ff @(posedge sd_clk) begin
    if (rst) begin
      st <= IDLE;
      dat_o <= 4'hF;
      dat_oe <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      underrun <= 1'b0;
      sreg <= '0;
      nib <= '0;
      nib_last <= '0;
      cnt <= '0;
`ifdef SD_TX_CRC_STATUS_EN
      crc_ok <= 1'b1;
      got_sb <= 1'b0;
      stat_sh <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (start) begin
          st <= PRE;
          dat_oe <= 1'b1;
          busy <= 1'b1;
          underrun <= 1'b0;
          nib_last <= NW'({blk_bytes, 1'b0} - 13'd1);
`ifdef SD_TX_CRC_STATUS_EN
          crc_ok <= 1'b1;
`endif
        end
        PRE: begin
          st <= STARTB;
          dat_o <= 4'h0;
        end
        STARTB, DATA: begin
          st <= last_nib ? CRC : DATA;
          dat_o <= last_nib ? crc_msb : nxt;
          sreg <= {(load ? ord[27:0] : sreg[27:0]), 4'h0};
          nib <= st == STARTB ? '0 : nib + NW'(1);
          cnt <= '0;
          if (load && fifo_empty) underrun <= 1'b1;
        end
        CRC: begin
          cnt <= cnt + 4'd1;
          st <= cnt == 4'(CRC_LEN - 1) ? ENDB : CRC;
          dat_o <= cnt == 4'(CRC_LEN - 1) ? 4'hF : crc_msb;
        end
        ENDB: begin
          dat_oe <= 1'b0;
          cnt <= '0;
`ifdef SD_TX_CRC_STATUS_EN
          st <= STAT;
          got_sb <= 1'b0;
`else
          st <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
`endif
        end
`ifdef SD_TX_CRC_STATUS_EN
        STAT: begin
          if (!got_sb) begin
            if (!dat_i[0]) begin
              got_sb <= 1'b1;
              cnt <= '0;
            end else if (cnt == 4'(STAT_TIMEOUT - 1)) begin
              crc_ok <= 1'b0;
              done <= 1'b1;
              busy <= 1'b0;
              st <= IDLE;
            end else cnt <= cnt + 4'd1;
          end else begin
            stat_sh <= {stat_sh[1:0], dat_i[0]};
            cnt <= cnt + 4'd1;
            if (cnt == 4'd3) begin
              crc_ok <= {stat_sh, dat_i[0]} == {STAT_OK, 1'b1};
              st <= BUSYW;
            end
          end
        end
        BUSYW: if (dat_i[0]) begin
          done <= 1'b1;
          busy <= 1'b0;
          st <= IDLE;
        end
`endif
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_data_tx.sv
// tb_sd_data_tx: randomized scoreboard bench for sd_data_tx against a block-level reference model.
module tb_sd_data_tx;
  logic clk = 1'b0;
  logic rst, start, fifo_empty, fifo_rd, dat_oe, busy, done, underrun, crc_ok;
  logic [11:0] blk_bytes;
  logic [31:0] fifo_data;
  logic [3:0] dat_i, dat_o;
  typedef struct {int cyc; int pops; logic und; logic ok;} done_t;
  localparam int BIG = 1 << 20;
  logic [3:0] exp_q[$];
  done_t done_q[$];
  done_t dd;
  logic [31:0] fifo_q[$];
  logic [31:0] words[$];
  int cyc = 0, checks = 0, errors = 0, mon_pops = 0, blk_pops = 0, empty_from = BIG, resp = 0, t_start = 0;
  logic force_empty = 1'b0, rd_seen = 1'b0, oe_q = 1'b0;

  sd_data_tx dut (
    .sd_clk(clk), .rst(rst), .start(start), .blk_bytes(blk_bytes),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .dat_i(dat_i), .dat_o(dat_o), .dat_oe(dat_oe), .busy(busy),
    .done(done), .underrun(underrun), .crc_ok(crc_ok)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, req, cyc);
    end
  endtask

  task automatic upd();
    fifo_empty = force_empty || fifo_q.size() == 0;
    fifo_data = fifo_q.size() != 0 ? fifo_q[0] : 32'h0;
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h1021 : 16'h0);
  endfunction

  // show-ahead FIFO model: pop takes effect just after the edge that consumed the head
  always @(negedge clk) rd_seen = fifo_rd;
  always begin
    @(posedge clk);
    #1;
    if (rd_seen && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      blk_pops++;
      if (blk_pops >= empty_from) force_empty = 1'b1;
      upd();
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_rd) mon_pops++;
      if (dat_oe) begin
        if (exp_q.size() == 0) chk("stream_extra_oe", dat_oe, 0);
        else chk("dat_o", dat_o, exp_q.pop_front());
      end
      if (done) begin
        if (done_q.size() == 0) chk("done_extra", done, 0);
        else begin
          dd = done_q.pop_front();
`ifndef SD_TX_CRC_STATUS_EN
          chk("done_cycle", cyc, dd.cyc);
`endif
          chk("pops", mon_pops, dd.pops);
          chk("underrun", underrun, dd.und);
          chk("crc_ok", crc_ok, dd.ok);
          chk("busy_at_done", busy, 0);
          chk("oe_at_done", dat_oe, 0);
          chk("stream_left", exp_q.size(), 0);
        end
      end
    end
  end

`ifdef SD_TX_CRC_STATUS_EN
  logic [4:0] bits;
  logic fall;
  initial begin
    dat_i = 4'hF;
    forever begin
      @(negedge clk);
      fall = oe_q && !dat_oe;
      oe_q = dat_oe;
      if (fall && busy && resp != 2) begin
        bits = resp == 0 ? 5'b00101 : 5'b01011;
        for (int i = 4; i >= 0; i--) begin @(posedge clk); #1 dat_i[0] = bits[i]; end
        repeat (20) begin @(posedge clk); #1 dat_i[0] = 1'b0; end
        @(posedge clk); #1 dat_i[0] = 1'b1;
      end
    end
  end
`else
  initial dat_i = 4'hF;
`endif

  task automatic fill(input int nw);
    words.delete();
    for (int i = 0; i < nw; i++) words.push_back($urandom);
  endtask

  task automatic issue(input int nb, input int efrom, input int rsp);
    int nw;
    logic [15:0] crc [4];
    logic [31:0] w;
    logic [3:0] nb4;
    done_t d;
    nw = nb / 4;
    fifo_q.delete();
    for (int i = 0; i < nw; i++) fifo_q.push_back(words[i]);
    force_empty = efrom == 0;
    blk_pops = 0;
    empty_from = efrom;
    resp = rsp;
    mon_pops = 0;
    upd();
    for (int k = 0; k < 4; k++) crc[k] = 16'h0;
    exp_q.push_back(4'hF);
    exp_q.push_back(4'h0);
    for (int i = 0; i < nw; i++) begin
      w = i < efrom ? words[i] : 32'h0;
      for (int n = 0; n < 8; n++) begin
        nb4 = 4'((w >> (8 * (n / 2) + 4 * (1 - n % 2))) & 32'hF);
        exp_q.push_back(nb4);
        for (int k = 0; k < 4; k++) crc[k] = crc_step(crc[k], nb4[k]);
      end
    end
    for (int b = 15; b >= 0; b--) exp_q.push_back({crc[3][b], crc[2][b], crc[1][b], crc[0][b]});
    exp_q.push_back(4'hF);
    d.cyc = cyc + 20 + 2 * nb;
    d.pops = nw < efrom ? nw : efrom;
    d.und = efrom < nw;
`ifdef SD_TX_CRC_STATUS_EN
    d.ok = rsp == 0;
`else
    d.ok = 1'b1;
`endif
    done_q.push_back(d);
    blk_bytes = 12'(nb);
    start = 1'b1;
    t_start = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    blk_bytes = 12'($urandom);
    chk("underrun_clear", underrun, 0);
    chk("busy_set", busy, 1);
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && done_q.size() != 0; i++) @(posedge clk);
    chk("done_seen", done_q.size(), 0);
    done_q.delete();
    exp_q.delete();
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    rst = 1'b1;
    start = 1'b0;
    blk_bytes = 12'h0;
    upd();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dat_o", dat_o, 4'hF);
    chk("rst_oe", dat_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_crc_ok", crc_ok, 1);
    chk("rst_fifo_rd", fifo_rd, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    words.delete();
    for (int i = 0; i < 128; i++) words.push_back(32'h0);
    issue(512, BIG, 0);
    wait_done(1200);
    words.delete();
    words.push_back(32'h87654321);
    issue(4, BIG, 0);
    wait_done(100);
    fill(16);
    issue(64, 3, 1);
    wait_done(300);
    fill(8);
    issue(32, BIG, 2);
    repeat (10) begin @(posedge clk); #1; end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_hold", busy, 1);
    wait_done(200);
    fill(32);
    issue(128, BIG, 0);
    while (cyc < t_start + 103) begin @(posedge clk); #1; end
    rst = 1'b1;
    exp_q.delete();
    done_q.delete();
    @(posedge clk);
    #1;
    chk("mid_rst_oe", dat_oe, 0);
    chk("mid_rst_dat_o", dat_o, 4'hF);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    fill(32);
    issue(128, BIG, 0);
    wait_done(400);
    for (int b = 0; b < 12; b++) begin
      nb = 4 * $urandom_range(1, 24);
      fill(nb / 4);
      issue(nb, $urandom_range(0, 3) == 0 ? int'($urandom_range(0, nb / 4)) : BIG, b % 3);
      wait_done(2 * nb + 100);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
